// File: rtl/matrixmul_3_pkg.sv
// rtl/matrixmul_3_pkg.sv - shared constants and FSM state type for the matrixmul_3 dot-product sequencer
package matrixmul_3_pkg;

    localparam int N         = 3;
    localparam int DW        = 32;
    localparam int AW        = 4;
    // Cycles between the last issue and a settled accumulator:
    // one for the memory read, one for the multiplier register.
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/matrixmul_3_mul_32s_32s_32_2_1.sv
// rtl/matrixmul_3_mul_32s_32s_32_2_1.sv - signed multiplier, truncated to dout width, NUM_STAGE-1 register stages, no reset
module matrixmul_3_mul_32s_32s_32_2_1 #(
    parameter int NUM_STAGE   = 2,
    parameter int din0_WIDTH  = 32,
    parameter int din1_WIDTH  = 32,
    parameter int dout_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    logic [dout_WIDTH-1:0] prod;
    logic [dout_WIDTH-1:0] pipe [NUM_STAGE-1];

    // Low dout_WIDTH bits of the signed product; modulo wrap is intended.
    assign prod = dout_WIDTH'($signed(din0) * $signed(din1));

    // Product pipeline advances only when enabled; contents are never reset.
    always_ff @(posedge clk) begin
        if (ce) begin
            pipe[0] <= prod;
            for (int s = 1; s < NUM_STAGE - 1; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    assign dout = pipe[NUM_STAGE-2];

endmodule

// File: rtl/matrixmul_3_dot_sched.sv
// rtl/matrixmul_3_dot_sched.sv - sequences C = A x B through one shared pipelined multiplier
module matrixmul_3_dot_sched #(
    parameter int N  = matrixmul_3_pkg::N,
    parameter int DW = matrixmul_3_pkg::DW,
    parameter int AW = matrixmul_3_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a_addr,
    output logic          a_ce,
    input  logic [DW-1:0] a_q,
    output logic [AW-1:0] b_addr,
    output logic          b_ce,
    input  logic [DW-1:0] b_q,
    output logic [AW-1:0] c_addr,
    output logic          c_we,
    output logic [DW-1:0] c_d
);

    import matrixmul_3_pkg::*;

    state_t        state, state_n;
    logic [AW-1:0] i, j, k;
    logic          drain_cnt;
    logic          v1, v2, first1, first2;
    logic [DW-1:0] acc;
    logic [DW-1:0] prod;
    logic          k_last, j_last, i_last;

    assign k_last = (k == AW'(N - 1));
    assign j_last = (j == AW'(N - 1));
    assign i_last = (i == AW'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and decoded outputs; addresses are held at zero outside their active state.
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        done    = 1'b0;
        a_ce    = 1'b0;
        b_ce    = 1'b0;
        c_we    = 1'b0;
        a_addr  = '0;
        b_addr  = '0;
        c_addr  = '0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_n = ISSUE;
            end
            ISSUE: begin
                a_ce   = 1'b1;
                b_ce   = 1'b1;
                a_addr = AW'(i * N + k);
                b_addr = AW'(k * N + j);
                if (k_last) state_n = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 1'(DRAIN_CYC - 1)) state_n = WRITE;
            end
            WRITE: begin
                c_we   = 1'b1;
                c_addr = AW'(i * N + j);
                state_n = (i_last && j_last) ? DONE : ISSUE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = ~ready;
    assign c_d  = acc;

    // Index counters and drain counter; k walks the dot product, j then i walk C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            drain_cnt <= 1'b0;
        end else begin
            drain_cnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                ISSUE: k <= k_last ? '0 : k + 1'b1;
                DRAIN: drain_cnt <= drain_cnt + 1'b1;
                WRITE: begin
                    if (j_last) begin
                        j <= '0;
                        i <= i_last ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid/first tags ride alongside the memory and multiplier latency; the first
    // product of each element overwrites acc, so stale multiplier contents never leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            first1 <= 1'b0;
            first2 <= 1'b0;
            acc    <= '0;
        end else begin
            v1     <= a_ce;
            first1 <= a_ce && (k == '0);
            v2     <= v1;
            first2 <= first1;
            if (v2) acc <= first2 ? prod : acc + prod;
        end
    end

    matrixmul_3_mul_32s_32s_32_2_1 #(
        .NUM_STAGE  (2),
        .din0_WIDTH (DW),
        .din1_WIDTH (DW),
        .dout_WIDTH (DW)
    ) u_mul (
        .clk  (clk),
        .ce   (v1),
        .din0 (a_q),
        .din1 (b_q),
        .dout (prod)
    );

endmodule

// File: tb/tb_matrixmul_3_dot_sched.sv
// tb/tb_matrixmul_3_dot_sched.sv - self-checking bench for matrixmul_3_dot_sched
module tb_matrixmul_3_dot_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ready, busy, done;
    logic [3:0]  a_addr, b_addr, c_addr;
    logic        a_ce, b_ce, c_we;
    logic [31:0] a_q, b_q, c_d;

    logic [31:0] amem [9];
    logic [31:0] bmem [9];
    logic [31:0] cmem [9];
    int          expc [9];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    matrixmul_3_dot_sched dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .a_addr (a_addr),
        .a_ce   (a_ce),
        .a_q    (a_q),
        .b_addr (b_addr),
        .b_ce   (b_ce),
        .b_q    (b_q),
        .c_addr (c_addr),
        .c_we   (c_we),
        .c_d    (c_d)
    );

    // 1-cycle-latency read memories and the C write memory.
    always @(posedge clk) begin
        if (a_ce) a_q <= amem[a_addr];
        if (b_ce) b_q <= bmem[b_addr];
        if (c_we && c_addr < 9) cmem[c_addr] <= c_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: textbook triple loop with 32-bit two's-complement wrap.
    task automatic model();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int s;
                s = 0;
                for (int m = 0; m < 3; m++) s += int'(amem[r*3+m]) * int'(bmem[m*3+c]);
                expc[r*3+c] = s;
            end
        end
    endtask

    // One full run; start sampled at edge 0, cycle t is the interval after edge t-1.
    task automatic run(input string name, input bit poke);
        int nw;
        int nd;
        nw = 0;
        nd = 0;
        model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 57; t++) begin
            @(negedge clk);
            start = poke && (t == 10 || t == 55);
            if (t <= 55) chk({name, "_busy"}, 32'(busy), 32'd1);
            if (c_we) begin
                if (nw < 9) begin
                    chk({name, "_wcyc"}, t, 6 * (nw + 1));
                    chk({name, "_waddr"}, 32'(c_addr), nw);
                    chk({name, "_wdata"}, c_d, expc[nw]);
                end else begin
                    chk({name, "_extra_write"}, 32'(nw), 32'd8);
                end
                nw++;
            end
            if (done) begin
                nd++;
                chk({name, "_done_cyc"}, t, 32'd55);
            end
            if (t == 56) chk({name, "_ready"}, 32'(ready), 32'd1);
        end
        chk({name, "_nwrites"}, nw, 32'd9);
        chk({name, "_ndone"}, nd, 32'd1);
    endtask

    task automatic fill_random();
        for (int e = 0; e < 9; e++) begin
            amem[e] = $urandom;
            bmem[e] = $urandom;
        end
    endtask

    initial begin
        int nw;
        reset = 1'b1;
        start = 1'b0;
        for (int e = 0; e < 9; e++) begin
            amem[e] = '0;
            bmem[e] = '0;
            cmem[e] = '0;
        end
        #2 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ces", {30'd0, a_ce, b_ce}, 32'd0);
        chk("rst_cwe", 32'(c_we), 32'd0);
        chk("rst_addrs", {20'd0, a_addr, b_addr, c_addr}, 32'd0);
        chk("rst_cd", c_d, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Identity times 1..9.
        for (int e = 0; e < 9; e++) begin
            amem[e] = (e % 4 == 0) ? 32'd1 : 32'd0;
            bmem[e] = 32'(e + 1);
        end
        run("ident", 1'b0);
        for (int e = 0; e < 9; e++) chk("ident_c", cmem[e], 32'(e + 1));

        // Signed operands.
        for (int e = 0; e < 9; e++) begin
            amem[e] = -32'sd3;
            bmem[e] = 32'sd4;
        end
        run("signed", 1'b0);
        chk("signed_c4", cmem[4], 32'hFFFFFFDC);

        // Wrap-around accumulation.
        for (int e = 0; e < 9; e++) begin
            amem[e] = (e < 3) ? 32'h7FFFFFFF : 32'd0;
            bmem[e] = (e % 3 == 0) ? 32'd2 : 32'd0;
        end
        run("wrap", 1'b0);
        chk("wrap_c00", cmem[0], 32'hFFFFFFFA);

        // Stale multiplier contents must not leak into the next element or run.
        for (int e = 0; e < 9; e++) begin
            amem[e] = 32'd5;
            bmem[e] = 32'd5;
        end
        run("fives", 1'b0);
        chk("fives_c8", cmem[8], 32'd75);
        for (int e = 0; e < 9; e++) begin
            amem[e] = 32'd0;
            bmem[e] = 32'd0;
        end
        run("zeros", 1'b0);
        for (int e = 0; e < 9; e++) chk("zeros_c", cmem[e], 32'd0);

        // Random data with start pulses during the run, including the DONE cycle.
        fill_random();
        run("poke", 1'b1);

        // Reset mid-run.
        fill_random();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cwe", 32'(c_we), 32'd0);
        nw = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 3) reset = 1'b1;
            if (c_we) nw++;
        end
        chk("midrst_nowrites", nw, 32'd0);
        run("after_rst", 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run("rand", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/matrixmul_3_dot_sched.md
Name: matrixmul_3_dot_sched

Overview:
Sequencer that computes C = A x B for N x N signed 32-bit matrices using one shared 1-stage pipelined signed multiplier (matrixmul_3_mul_32s_32s_32_2_1).
- Reads A and B from external 1-cycle-latency memories, drives the multiplier clock enable and accumulates each dot product.
- Writes each C element to an output memory.
- Sits between the matrixmul_3 top-level start/done handshake and the array memories.

Parameters:
N, 3, matrix dimension (N >= 2).
DW, 32, data width of A, B, C elements and of the accumulator.
AW, 4, memory address width, >= ceil(log2(N*N)).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  begin a computation; sampled only in IDLE.
ready  out  1  high in IDLE.
busy  out  1  high in ISSUE/DRAIN/WRITE/DONE.
done  out  1  one-cycle pulse after the last C write.
a_addr  out  AW  A read address, row-major (i*N+k).
a_ce  out  1  A read enable.
a_q  in  DW  A read data, valid one cycle after a_ce.
b_addr  out  AW  B read address (k*N+j).
b_ce  out  1  B read enable.
b_q  in  DW  B read data, valid one cycle after b_ce.
c_addr  out  AW  C write address (i*N+j).
c_we  out  1  C write enable.
c_d  out  DW  C write data (accumulator).

Behaviour:
- Reset (asynchronous assert, any state):
  - FSM goes to IDLE; i, j, k = 0; valid pipe and acc = 0.
  - Outputs: ready=1, busy=0, done=0, a_ce=b_ce=c_we=0, all addresses 0, c_d=0.
  - A reset mid-operation abandons the computation; no further c_we.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
  - IDLE: start=1 at an edge moves to ISSUE with i=j=k=0.
  - ISSUE: a_ce=b_ce=1, addresses from (i,j,k), k increments each cycle. After k=N-1, go to DRAIN with k=0.
  - DRAIN: exactly 2 cycles, counted by a 1-bit drain counter; then WRITE.
  - WRITE: c_we=1 for one cycle, c_addr=i*N+j, c_d=acc. Then advance j; on j=N-1, set j=0 and advance i. If i=N-1 and j=N-1, go to DONE; else go to ISSUE.
  - DONE: done=1 for one cycle, busy=1, then IDLE.
- Pipeline:
  - v1 = registered (a_ce). Memory data is valid in the cycle where v1=1.
  - Multiplier din0=a_q, din1=b_q, ce=v1.
  - v2 = registered v1. The product is valid in the cycle where v2=1.
  - first1/first2 track k==0 alongside v1/v2. On v2: acc <= first2 ? product : acc + product.
  - The multiplier has no reset. The first-flag overwrite guarantees stale products never reach acc.
- Timing: start high at edge 0.
  - Element e occupies cycles 6e+1..6e+6 (N=3): ISSUE 3, DRAIN 2, WRITE 1. Generally N+3 cycles per element.
  - Last write at cycle N*N*(N+3); done in the next cycle; ready=1 in the cycle after that.
- Arithmetic: two's-complement with modulo 2^DW wrap. Product is truncated to DW by the multiplier; acc addition wraps. No saturation, no overflow flag.
- start while not in IDLE, including the DONE cycle, is ignored; it is not queued.
- a_q/b_q are ignored when v1=0.

Decomposition:
- Package matrixmul_3_pkg:
  - FSM state enum (IDLE, ISSUE, DRAIN, WRITE, DONE).
  - Constants N, DW, AW.
  - DRAIN_CYC=2: multiplier latency 1 + memory latency 1.
- Sub-module: instantiate the existing matrixmul_3_mul_32s_32s_32_2_1 (din0/din1/dout widths = DW, NUM_STAGE=2). The index counters, address generation and accumulator stay in this block.

Test Plan:
- Identity: A=I, B=[1..9] row-major, start at cycle 0 -> C=[1..9]; nine c_we pulses at cycles 6,12,...,54; done at 55; ready at 56.
- Signed: A all -3, B all 4 -> every C element = -36 (0xFFFFFFDC); c_addr sequence 0..8.
- Wrap: A[0][*]=0x7FFFFFFF, B[*][0]=2 -> C[0][0] = 3*0xFFFFFFFE mod 2^32 = 0xFFFFFFFA.
- Stale data: run A=B=all 5 (C=75 everywhere), then A=B=0 -> all C=0; checks first-product overwrite.
- start pulsed at cycles 10 and 55 during a run -> ignored; exactly 9 writes, one done pulse.
- reset low at cycle 20 -> same cycle: ready=1, busy=0, c_we=0; no writes until the next start; a new run after release produces a correct full C.
